image_read_stream: RTL and testbench
====================================

Name: image_read_stream

Overview:
- Frame source for the RGB888 pixel-pair stream consumed by the image writer.
- Holds one WIDTH x HEIGHT frame in an internal byte buffer loaded through a simple write port.
- On `start`, emits a VSYNC interval, then per row a blanking gap followed by WIDTH/2 HSYNC-qualified cycles, each carrying two pixels (R0 G0 B0 R1 G1 B1).
- Used as the stimulus side of the watermarking datapath and in loopback against the writer.

Parameters:
- WIDTH, 8, image width in pixels; must be even and >= 2.
- HEIGHT, 8, image height in rows; >= 1.
- ADDR_W, 8, byte address width; 2**ADDR_W >= WIDTH*HEIGHT*3.
- START_UP_DELAY, 100, VSYNC-high cycles before the first row; >= 1.
- HSYNC_DELAY, 160, blank cycles before each row; >= 1.

Ports:
- HCLK  in  1  clock; all logic on rising edge.
- HRESETn  in  1  reset, synchronous, active-low.
- load_en  in  1  byte write strobe into the frame buffer.
- load_addr  in  ADDR_W  byte address. Layout is row-major, 3 bytes per pixel, R then G then B.
- load_data  in  8  byte to write.
- start  in  1  single-cycle request to stream one frame.
- busy  out  1  high while a frame is in progress (state != IDLE).
- VSYNC  out  1  frame start interval.
- HSYNC  out  1  qualifies DATA_* as a valid pixel pair.
- DATA_R0, DATA_G0, DATA_B0  out  8 each  even-indexed pixel of the pair.
- DATA_R1, DATA_G1, DATA_B1  out  8 each  odd-indexed pixel of the pair.
- ctrl_done  out  1  one-cycle pulse after the last pair of the frame.

Behaviour:
- Reset: synchronous on HRESETn==0 at a rising edge.
  - State -> IDLE.
  - busy, VSYNC, HSYNC, ctrl_done -> 0; all DATA_* -> 0; row, column and delay counters -> 0.
  - Frame buffer contents are NOT cleared and are retained across reset.
- Frame buffer:
  - Written when load_en=1 and state==IDLE.
  - load_en outside IDLE is ignored and the buffer is unchanged.
  - load_addr >= WIDTH*HEIGHT*3 is ignored.
- States: IDLE, VSYNC, HBLANK, DATA, DONE. All outputs are registered and valid in the cycle the state is occupied.
- IDLE:
  - start=1 -> VSYNC. Delay counter=0, row=0.
  - start with load_en in the same cycle: the load is performed, then the frame starts.
- VSYNC:
  - VSYNC=1 for exactly START_UP_DELAY cycles.
  - Then -> HBLANK.
- HBLANK:
  - VSYNC=0, HSYNC=0 for exactly HSYNC_DELAY cycles.
  - Then -> DATA with col=0.
- DATA:
  - HSYNC=1 for exactly WIDTH/2 consecutive cycles.
  - Pair k of row r is taken from base = (r*WIDTH + 2k)*3: R0=buf[base], G0=+1, B0=+2, R1=+3, G1=+4, B1=+5.
  - After col=WIDTH/2-1: if r==HEIGHT-1 -> DONE, else row+1 -> HBLANK.
- DONE:
  - ctrl_done=1 for one cycle, HSYNC=0.
  - Then -> IDLE.
- DATA_* outside DATA: hold their last value; only HSYNC qualifies them.
- Latency: with start sampled at edge n, VSYNC first reads 1 in cycle n+1.
- Frame length from start to ctrl_done pulse: START_UP_DELAY + HEIGHT*(HSYNC_DELAY + WIDTH/2) + 1 cycles.
- busy: 1 from the cycle after start through the DONE cycle inclusive; 0 in IDLE.
- start while busy is ignored and never queued.
- Reset mid-frame: returns to IDLE next edge with outputs zeroed; no ctrl_done pulse. A new start replays the frame from row 0.
- Counter widths: sized for the largest of START_UP_DELAY, HSYNC_DELAY, WIDTH/2 and HEIGHT; no wrap inside a frame.

Test Plan:
- Common setup: WIDTH=8, HEIGHT=8, START_UP_DELAY=4, HSYNC_DELAY=2; load buf[i]=i for i=0..191.
- Basic frame, single start pulse:
  - VSYNC=1 for 4 cycles, then per row 2 blank cycles plus 4 HSYNC cycles.
  - First pair is 00,01,02,03,04,05.
  - Row 1 first pair is 0x18..0x1D; last pair is 0xBA..0xBF.
  - ctrl_done pulses at cycle 53 after start; exactly 32 HSYNC-high cycles.
- start pulsed again at rows 2 and 7 -> ignored; output stream identical to the basic frame; busy stays 1.
- load_en with addr 0 and data 0xFF while busy -> ignored; a second frame still emits 00 as the first R0.
- HRESETn=0 during row 3 DATA:
  - Next cycle all outputs 0, busy=0, no ctrl_done.
  - A new start replays the frame from 00,01,...; buffer retained.
- Loopback into the image writer with matching WIDTH/HEIGHT: the writer's captured bytes 0..191 equal the loaded pattern in order.

Source files
------------

// File: rtl/image_read_stream.sv
// Frame source: buffers one RGB888 frame and streams it as HSYNC-qualified pixel pairs
// preceded by a VSYNC interval and per-row blanking.
module image_read_stream #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned HEIGHT         = 8,
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned START_UP_DELAY = 100,
    parameter int unsigned HSYNC_DELAY    = 160
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    input  logic              start,
    output logic              busy,
    output logic              VSYNC,
    output logic              HSYNC,
    output logic [7:0]        DATA_R0,
    output logic [7:0]        DATA_G0,
    output logic [7:0]        DATA_B0,
    output logic [7:0]        DATA_R1,
    output logic [7:0]        DATA_G1,
    output logic [7:0]        DATA_B1,
    output logic              ctrl_done
);

    localparam int unsigned FRAME_BYTES = WIDTH * HEIGHT * 3;
    localparam int unsigned MEM_DEPTH   = 1 << ADDR_W;
    localparam int unsigned PAIRS       = WIDTH / 2;
    localparam int unsigned MAX_DLY     = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
    localparam int unsigned MAX_POS     = (PAIRS > HEIGHT) ? PAIRS : HEIGHT;
    localparam int unsigned MAX_CNT     = (MAX_DLY > MAX_POS) ? MAX_DLY : MAX_POS;
    localparam int unsigned CNT_W       = $clog2(MAX_CNT + 1);
    localparam int unsigned PAIR_W      = 48;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_HBLANK,
        S_DATA,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    row_q, row_d;
    logic [CNT_W-1:0]    col_q, col_d;
    logic [PAIR_W-1:0]   pair_q, pair_d;
    logic                busy_q, busy_d;
    logic                vsync_q, vsync_d;
    logic                hsync_q, hsync_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   base_c;
    logic                load_we_c;

    logic [7:0] mem_q [MEM_DEPTH];

    // Buffer is only writable while idle; it has no reset so contents survive HRESETn.
    assign load_we_c = load_en && (state_q == S_IDLE) && (32'(load_addr) < FRAME_BYTES);

    always_ff @(posedge HCLK) begin
        if (load_we_c) begin
            mem_q[load_addr] <= load_data;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            pair_q  <= '0;
            busy_q  <= 1'b0;
            vsync_q <= 1'b0;
            hsync_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pair_q  <= pair_d;
            busy_q  <= busy_d;
            vsync_q <= vsync_d;
            hsync_q <= hsync_d;
            done_q  <= done_d;
        end
    end

    // Outputs are derived from the next state so they are valid in the cycle the state is held.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        pair_d  = pair_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_VSYNC;
                    cnt_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_VSYNC: begin
                if (cnt_q == CNT_W'(START_UP_DELAY - 1)) begin
                    state_d = S_HBLANK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HBLANK: begin
                if (cnt_q == CNT_W'(HSYNC_DELAY - 1)) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    col_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (col_q == CNT_W'(PAIRS - 1)) begin
                    if (row_q == CNT_W'(HEIGHT - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_HBLANK;
                        row_d   = row_q + CNT_W'(1);
                    end
                end else begin
                    col_d = col_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        base_c = ADDR_W'(((32'(row_d) * WIDTH) + (32'(col_d) * 2)) * 3);
        if (state_d == S_DATA) begin
            pair_d = {mem_q[base_c],
                      mem_q[base_c + ADDR_W'(1)],
                      mem_q[base_c + ADDR_W'(2)],
                      mem_q[base_c + ADDR_W'(3)],
                      mem_q[base_c + ADDR_W'(4)],
                      mem_q[base_c + ADDR_W'(5)]};
        end

        busy_d  = (state_d != S_IDLE);
        vsync_d = (state_d == S_VSYNC);
        hsync_d = (state_d == S_DATA);
        done_d  = (state_d == S_DONE);
    end

    assign busy      = busy_q;
    assign VSYNC     = vsync_q;
    assign HSYNC     = hsync_q;
    assign ctrl_done = done_q;
    assign DATA_R0   = pair_q[47:40];
    assign DATA_G0   = pair_q[39:32];
    assign DATA_B0   = pair_q[31:24];
    assign DATA_R1   = pair_q[23:16];
    assign DATA_G1   = pair_q[15:8];
    assign DATA_B1   = pair_q[7:0];

endmodule

// File: tb/tb_image_read_stream.sv
// Scoreboard bench for image_read_stream: expected pairs are queued per frame and a
// negedge monitor pops one for every HSYNC-qualified cycle.
module tb_image_read_stream;

    localparam int unsigned W   = 8;
    localparam int unsigned H   = 8;
    localparam int unsigned AW  = 8;
    localparam int unsigned SUD = 4;
    localparam int unsigned HD  = 2;

    logic        clk;
    logic        rst_n;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [7:0]  load_data;
    logic        start;
    logic        busy;
    logic        vsync;
    logic        hsync;
    logic [7:0]  r0, g0, b0, r1, g1, b1;
    logic        ctrl_done;

    int checks;
    int fails;
    logic [47:0] exp_q [$];

    image_read_stream #(
        .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .START_UP_DELAY(SUD), .HSYNC_DELAY(HD)
    ) dut (
        .HCLK(clk), .HRESETn(rst_n),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .start(start), .busy(busy), .VSYNC(vsync), .HSYNC(hsync),
        .DATA_R0(r0), .DATA_G0(g0), .DATA_B0(b0),
        .DATA_R1(r1), .DATA_G1(g1), .DATA_B1(b1),
        .ctrl_done(ctrl_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected stream for one full frame of the i -> i byte pattern.
    task automatic push_frame();
        for (int r = 0; r < int'(H); r++) begin
            for (int c = 0; c < int'(W / 2); c++) begin
                int base;
                base = (r * int'(W) + 2 * c) * 3;
                exp_q.push_back({8'(base), 8'(base + 1), 8'(base + 2),
                                 8'(base + 3), 8'(base + 4), 8'(base + 5)});
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && hsync) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL pair_unexpected: got %0h with no entry queued",
                         {r0, g0, b0, r1, g1, b1});
            end else begin
                chk("pair", {r0, g0, b0, r1, g1, b1}, exp_q.pop_front());
            end
        end
    end

    // One frame: start is sampled at the edge before k=1. Optionally retrigger start
    // during rows 2 and 7 and attempt a load while busy.
    task automatic run_frame(input bit inject);
        int vs_n, hs_n, done_n, done_k, busy_bad, first_hs;
        vs_n = 0; hs_n = 0; done_n = 0; done_k = 0; busy_bad = 0; first_hs = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 56; k++) begin
            @(negedge clk);
            start   = 1'b0;
            load_en = 1'b0;
            if (inject && (k == 19 || k == 49)) start = 1'b1;
            if (inject && k == 10) begin
                load_en   = 1'b1;
                load_addr = 8'h00;
                load_data = 8'hFF;
            end
            if (k == 1) chk("vsync_first", 48'(vsync), 48'd1);
            if (vsync) vs_n++;
            if (hsync) begin
                hs_n++;
                if (first_hs == 0) first_hs = k;
            end
            if (ctrl_done) begin
                done_n++;
                done_k = k;
            end
            if ((k <= 53) != busy) busy_bad++;
        end
        chk("vsync_cycles", 48'(vs_n), 48'd4);
        chk("first_hsync_cycle", 48'(first_hs), 48'd7);
        chk("hsync_cycles", 48'(hs_n), 48'd32);
        chk("done_pulses", 48'(done_n), 48'd1);
        chk("done_cycle", 48'(done_k), 48'd53);
        chk("busy_window", 48'(busy_bad), 48'd0);
        chk("pairs_left", 48'(exp_q.size()), 48'd0);
        chk("idle_hold_last_pair", {r0, g0, b0, r1, g1, b1}, 48'hBABBBCBDBEBF);
        chk("idle_hsync", 48'(hsync), 48'd0);
    endtask

    // Frame aborted by reset during row 3 DATA (k=25..28).
    task automatic reset_frame(input int rk);
        int bad;
        bad = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= rk; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("row3_hsync_before_reset", 48'(hsync), 48'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_busy", 48'(busy), 48'd0);
        chk("rst_vsync", 48'(vsync), 48'd0);
        chk("rst_hsync", 48'(hsync), 48'd0);
        chk("rst_done", 48'(ctrl_done), 48'd0);
        chk("rst_pair", {r0, g0, b0, r1, g1, b1}, 48'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ctrl_done || busy || hsync) bad++;
        end
        chk("no_activity_after_reset", 48'(bad), 48'd0);
        exp_q.delete();
    endtask

    initial begin
        checks    = 0;
        fails     = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 48'(busy), 48'd0);
        chk("reset_vsync", 48'(vsync), 48'd0);
        chk("reset_hsync", 48'(hsync), 48'd0);
        chk("reset_done", 48'(ctrl_done), 48'd0);
        chk("reset_pair", {r0, g0, b0, r1, g1, b1}, 48'd0);
        rst_n = 1'b1;

        for (int i = 0; i < int'(W * H * 3); i++) begin
            @(negedge clk);
            load_en   = 1'b1;
            load_addr = 8'(i);
            load_data = 8'(i);
        end
        @(negedge clk);
        load_en = 1'b0;

        push_frame();
        run_frame(1'b0);
        push_frame();
        run_frame(1'b1);
        push_frame();
        reset_frame(26);
        push_frame();
        run_frame(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
